// File: rtl/timer_pkg.sv
// Shared register map and control-bit layout for the multi-channel timer.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_COMPARE = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQEN   = 2;
  localparam int CTRL_W       = 3;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PERIOD/COMPARE registers, up-counter and sticky
// overflow/match flags. Advances only on the shared prescaler tick.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_tick,
  input  logic             i_wr_en,
  input  logic [1:0]       i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_overflow,
  output logic             o_match,
  output logic             o_irq_en
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [WIDTH-1:0]  period_q;
  logic [WIDTH-1:0]  compare_q;
  logic [WIDTH-1:0]  count_q;
  logic              ovf_q;
  logic              match_q;

  logic [WIDTH-1:0]  count_nxt;
  logic              ovf_set;
  logic              match_set;
  logic              stop;
  logic              wr_ctrl;
  logic              restart;

  // Next count is computed from the registers as they stand before this edge,
  // so a write landing on a tick edge only affects later ticks.
  always_comb begin
    count_nxt = count_q;
    ovf_set   = 1'b0;
    match_set = 1'b0;
    stop      = 1'b0;
    if (i_tick && ctrl_q[CTRL_EN]) begin
      if (count_q == period_q) begin
        count_nxt = '0;
        ovf_set   = 1'b1;
        stop      = ctrl_q[CTRL_ONESHOT];
      end else begin
        count_nxt = count_q + 1'b1;
        ovf_set   = (count_q == '1);
      end
      match_set = (count_nxt == compare_q) && (compare_q <= period_q);
    end
  end

  // A one-shot channel re-armed from idle starts over; auto-reload resumes.
  assign wr_ctrl = i_wr_en && (i_wr_addr == ADDR_CTRL);
  assign restart = wr_ctrl && !ctrl_q[CTRL_EN] && i_wr_data[CTRL_EN] && i_wr_data[CTRL_ONESHOT];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ctrl_q    <= '0;
      period_q  <= '1;
      compare_q <= '1;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      count_q <= restart ? '0 : count_nxt;
      if (wr_ctrl) begin
        ctrl_q <= i_wr_data[CTRL_W-1:0];
      end else if (stop) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end
      if (i_wr_en && (i_wr_addr == ADDR_PERIOD)) begin
        period_q <= i_wr_data;
      end
      if (i_wr_en && (i_wr_addr == ADDR_COMPARE)) begin
        compare_q <= i_wr_data;
      end
      // Set has priority over a clear arriving on the same edge.
      ovf_q   <= ovf_set   | (ovf_q   & ~i_clear);
      match_q <= match_set | (match_q & ~i_clear);
    end
  end

  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_match    = match_q;
  assign o_irq_en   = ctrl_q[CTRL_IRQEN];

endmodule

// File: rtl/timer_multich.sv
// N-channel up-counting timer: shared prescaler, register write decode,
// coherent count snapshot and combined interrupt.
module timer_multich
  import timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N_CH    = 4,
  parameter int PRESC_W = 8
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset,
  input  logic                                      i_enable,
  input  logic [PRESC_W-1:0]                        i_prescale,
  input  logic                                      i_wr_en,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] i_wr_ch,
  input  logic [1:0]                                i_wr_addr,
  input  logic [WIDTH-1:0]                          i_wr_data,
  input  logic [N_CH-1:0]                           i_clearw,
  input  logic                                      i_showtime,
  output logic [N_CH*WIDTH-1:0]                     o_currentv,
  output logic [N_CH-1:0]                           o_overflow,
  output logic [N_CH-1:0]                           o_match,
  output logic                                      o_irq
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PRESC_W-1:0]    presc_q;
  logic                  tick;
  logic [N_CH*WIDTH-1:0] count_flat;
  logic [N_CH-1:0]       irq_en;
  logic [N_CH-1:0]       irq_vec;

  // Prescaler holds its phase while globally disabled.
  assign tick = i_enable && (presc_q == i_prescale);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      presc_q <= '0;
    end else if (i_enable) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  // Write port: i_wr_en is a single-cycle strobe with no back-pressure; the
  // addressed register updates on the same rising edge the strobe is seen.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(g);

    timer_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_tick     (tick),
      .i_wr_en    (i_wr_en && (i_wr_ch == CH_ID)),
      .i_wr_addr  (i_wr_addr),
      .i_wr_data  (i_wr_data),
      .i_clear    (i_clearw[g]),
      .o_count    (count_flat[g*WIDTH +: WIDTH]),
      .o_overflow (o_overflow[g]),
      .o_match    (o_match[g]),
      .o_irq_en   (irq_en[g])
    );

    assign irq_vec[g] = (o_overflow[g] | o_match[g]) & irq_en[g];
  end

  assign o_irq = |irq_vec;

  // All channels are captured together so software sees one coherent instant.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_currentv <= '0;
    end else if (i_showtime) begin
      o_currentv <= count_flat;
    end
  end

endmodule

// File: tb/tb_timer_multich.sv
// Directed bench for timer_multich: reference count model feeding an expected
// snapshot queue, plus hand-timed prescaler/one-shot checks.
module tb_timer_multich;
  import timer_pkg::*;

  localparam int W  = 8;
  localparam int NC = 4;
  localparam int PW = 8;
  localparam int VW = NC * W;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic [PW-1:0] i_prescale;
  logic          i_wr_en;
  logic [1:0]    i_wr_ch;
  logic [1:0]    i_wr_addr;
  logic [W-1:0]  i_wr_data;
  logic [NC-1:0] i_clearw;
  logic          i_showtime;
  logic [VW-1:0] o_currentv;
  logic [NC-1:0] o_overflow;
  logic [NC-1:0] o_match;
  logic          o_irq;

  int n_pass;
  int n_total;

  logic [VW-1:0] exp_q[$];

  // Reference model state for the single active auto-reload channel.
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_period;
  logic [W-1:0] m_compare;
  logic [W-1:0] m_cv;
  logic         m_ovf;
  logic         m_match;
  logic         m_irqen;

  timer_multich #(
    .WIDTH   (W),
    .N_CH    (NC),
    .PRESC_W (PW)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_prescale (i_prescale),
    .i_wr_en    (i_wr_en),
    .i_wr_ch    (i_wr_ch),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_clearw   (i_clearw),
    .i_showtime (i_showtime),
    .o_currentv (o_currentv),
    .o_overflow (o_overflow),
    .o_match    (o_match),
    .o_irq      (o_irq)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step(3);
    i_reset = 1'b0;
  endtask

  // Driver tasks
  task automatic wr(input int ch, input logic [1:0] addr, input logic [W-1:0] data);
    i_wr_en   = 1'b1;
    i_wr_ch   = ch[1:0];
    i_wr_addr = addr;
    i_wr_data = data;
    step(1);
    i_wr_en   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_init(input logic [W-1:0] period, input logic irqen);
    m_cnt     = '0;
    m_period  = period;
    m_compare = '1;
    m_cv      = '0;
    m_ovf     = 1'b0;
    m_match   = 1'b0;
    m_irqen   = irqen;
  endtask

  // Runs n ticks (prescale 0) on channel ch with optional snapshot freeze
  // window [st_off, st_on), clear pulses and one PERIOD rewrite at wr_k.
  task automatic run_model(input int ch, input int n, input int st_off, input int st_on,
                           input int clr_a, input int clr_b, input int wr_k,
                           input logic [W-1:0] wr_val);
    logic [W-1:0]  nxt;
    logic          set_o;
    logic          clr;
    logic          st;
    logic [VW-1:0] exp_vec;
    logic [NC-1:0] exp_flag;
    for (int k = 1; k <= n; k++) begin
      st  = !(k >= st_off && k < st_on);
      clr = (k == clr_a) || (k == clr_b);
      i_showtime  = st;
      i_clearw    = '0;
      i_clearw[ch] = clr;
      if (k == wr_k) begin
        i_wr_en   = 1'b1;
        i_wr_ch   = ch[1:0];
        i_wr_addr = ADDR_PERIOD;
        i_wr_data = wr_val;
      end
      if (st) m_cv = m_cnt;
      exp_vec = '0;
      exp_vec[ch*W +: W] = m_cv;
      exp_q.push_back(exp_vec);
      if (m_cnt == m_period) begin
        nxt   = '0;
        set_o = 1'b1;
      end else begin
        nxt   = m_cnt + 8'd1;
        set_o = (m_cnt == 8'hFF);
      end
      m_match = ((nxt == m_compare) && (m_compare <= m_period)) | (m_match & !clr);
      m_ovf   = set_o | (m_ovf & !clr);
      if (k == wr_k) m_period = wr_val;
      m_cnt = nxt;
      step(1);
      i_wr_en  = 1'b0;
      i_clearw = '0;
      chk($sformatf("cv ch%0d k=%0d", ch, k), o_currentv, exp_q.pop_front());
      exp_flag = '0;
      exp_flag[ch] = m_ovf;
      chk($sformatf("ovf ch%0d k=%0d", ch, k), o_overflow, exp_flag);
      exp_flag = '0;
      exp_flag[ch] = m_match;
      chk($sformatf("match ch%0d k=%0d", ch, k), o_match, exp_flag);
      chk($sformatf("irq ch%0d k=%0d", ch, k), o_irq, (m_ovf | m_match) & m_irqen);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " cv"}, o_currentv, '0);
    chk({tag, " ovf"}, o_overflow, '0);
    chk({tag, " match"}, o_match, '0);
    chk({tag, " irq"}, o_irq, 1'b0);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    i_reset    = 1'b1;
    i_enable   = 1'b0;
    i_prescale = '0;
    i_wr_en    = 1'b0;
    i_wr_ch    = '0;
    i_wr_addr  = '0;
    i_wr_data  = '0;
    i_clearw   = '0;
    i_showtime = 1'b1;

    do_reset();
    chk_idle("reset");

    // Auto-reload PERIOD=4 on ch0, clear colliding with overflow at k=10
    i_enable   = 1'b1;
    i_prescale = '0;
    wr(0, ADDR_PERIOD, 8'd4);
    wr(0, ADDR_CTRL, 8'h05);
    model_init(8'd4, 1'b1);
    run_model(0, 17, 0, 0, 10, 12, 0, 8'd0);

    // Reset while counting with flags and irq raised
    do_reset();
    chk_idle("midrun reset");

    // Default PERIOD/COMPARE all-ones on ch3, snapshot frozen at 7
    wr(3, ADDR_CTRL, 8'h05);
    model_init(8'hFF, 1'b1);
    run_model(3, 258, 9, 19, 0, 0, 0, 8'd0);

    // PERIOD reprogrammed below running count: wraps through 255
    do_reset();
    wr(2, ADDR_CTRL, 8'h01);
    model_init(8'hFF, 1'b0);
    run_model(2, 262, 0, 0, 0, 0, 11, 8'd2);

    // Prescale 3, ch1 one-shot PERIOD=2 COMPARE=1 with irq
    do_reset();
    i_enable   = 1'b0;
    i_prescale = 8'd3;
    wr(1, ADDR_PERIOD, 8'd2);
    wr(1, ADDR_COMPARE, 8'd1);
    wr(1, ADDR_CTRL, 8'h07);
    i_enable = 1'b1;
    step(3);
    chk("os pre-tick match", o_match, 4'b0000);
    chk("os pre-tick irq", o_irq, 1'b0);
    step(1);
    chk("os tick1 match", o_match, 4'b0010);
    chk("os tick1 ovf", o_overflow, 4'b0000);
    chk("os tick1 irq", o_irq, 1'b1);
    step(1);
    chk("os tick1 cv", o_currentv, 32'h0000_0100);
    step(3);
    chk("os tick2 ovf", o_overflow, 4'b0000);
    chk("os tick2 cv lag", o_currentv, 32'h0000_0100);
    step(1);
    chk("os tick2 cv", o_currentv, 32'h0000_0200);
    step(3);
    chk("os tick3 ovf", o_overflow, 4'b0010);
    chk("os tick3 irq", o_irq, 1'b1);
    step(1);
    chk("os tick3 cv", o_currentv, 32'h0000_0000);
    step(8);
    chk("os held cv", o_currentv, 32'h0000_0000);
    chk("os held ovf", o_overflow, 4'b0010);
    chk("os held match", o_match, 4'b0010);
    chk("os held irq", o_irq, 1'b1);
    i_clearw = 4'b0010;
    step(1);
    i_clearw = '0;
    chk("os cleared ovf", o_overflow, 4'b0000);
    chk("os cleared match", o_match, 4'b0000);
    chk("os cleared irq", o_irq, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
